// File: rtl/alu_seq_pkg.sv
// alu_seq shared definitions: opcodes, ALU op codes, FSM states, widths.
// Optional feature macro: ALU_SEQ_ZERO_EN (adds rsp_zero output in alu_seq).
package alu_seq_pkg;

    localparam int IDX_W  = 2;
    localparam int DATA_W = 8;
    localparam int NREGS  = 1 << IDX_W;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_LOADI = 3'b100;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Opcodes 000-011 map one-to-one onto the external ALU's op codes.
    function automatic logic is_alu_op(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

endpackage

// File: rtl/alu_seq_rf.sv
// alu_seq register file: 4x8, two async read ports, one sync write port.
// Ports: clk, rst_n (async low), i_ra/i_rb addr -> o_ra/o_rb data, i_we/i_wa/i_wd.
module alu_seq_rf
    import alu_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  i_ra_addr,
    output logic [DATA_W-1:0] o_ra_data,
    input  logic [IDX_W-1:0]  i_rb_addr,
    output logic [DATA_W-1:0] o_rb_data,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_wa,
    input  logic [DATA_W-1:0] i_wd
);

    logic [DATA_W-1:0] r_mem [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_wa] <= i_wd;
        end
    end

    assign o_ra_data = r_mem[i_ra_addr];
    assign o_rb_data = r_mem[i_rb_addr];

endmodule

// File: rtl/alu_seq.sv
// alu_seq: command sequencer driving an external 8-bit ALU over a 4-entry RF.
// Ports: cmd_* in (valid/ready), alu_* to/from ALU, rsp_* out (valid/ready).
// Optional: ALU_SEQ_ZERO_EN adds rsp_zero (registered rsp_data==0 flag).
module alu_seq
    import alu_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [IDX_W-1:0]  cmd_dst,
    input  logic [IDX_W-1:0]  cmd_srca,
    input  logic [IDX_W-1:0]  cmd_srcb,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [1:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_o,
    input  logic              alu_cout,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_carry
`ifdef ALU_SEQ_ZERO_EN
    ,
    output logic              rsp_zero
`endif
);

    state_t            r_state;
    state_t            w_state_nxt;

    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [1:0]        r_alu_op;
    logic [IDX_W-1:0]  r_dst;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_carry;

    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;
    logic              w_rf_we;
    logic [IDX_W-1:0]  w_rf_wa;
    logic [DATA_W-1:0] w_rf_wd;
    logic              w_lat_ops;
    logic              w_cap;
    logic [DATA_W-1:0] w_cap_data;
    logic              w_cap_carry;

    // Reads are combinational off the command, so operands are sampled
    // before any write at the same edge (dst may alias a source).
    alu_seq_rf u_rf (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_ra_addr (cmd_srca),
        .o_ra_data (w_rd_a),
        .i_rb_addr (cmd_srcb),
        .o_rb_data (w_rd_b),
        .i_we      (w_rf_we),
        .i_wa      (w_rf_wa),
        .i_wd      (w_rf_wd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rf_we     = 1'b0;
        w_rf_wa     = cmd_dst;
        w_rf_wd     = cmd_imm;
        w_lat_ops   = 1'b0;
        w_cap       = 1'b0;
        w_cap_data  = '0;
        w_cap_carry = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (is_alu_op(cmd_op)) begin
                        w_lat_ops   = 1'b1;
                        w_state_nxt = S_EXEC;
                    end else begin
                        // LOADI and reserved share the short path;
                        // reserved responds with zero and no write.
                        w_cap       = 1'b1;
                        w_state_nxt = S_RESP;
                        if (cmd_op == OP_LOADI) begin
                            w_rf_we    = 1'b1;
                            w_cap_data = cmd_imm;
                        end
                    end
                end
            end
            S_EXEC: begin
                w_rf_we     = 1'b1;
                w_rf_wa     = r_dst;
                w_rf_wd     = alu_o;
                w_cap       = 1'b1;
                w_cap_data  = alu_o;
                w_cap_carry = alu_cout;
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= ALU_ADD;
            r_dst       <= '0;
            r_rsp_data  <= '0;
            r_rsp_carry <= 1'b0;
        end else begin
            if (w_lat_ops) begin
                r_alu_a  <= w_rd_a;
                r_alu_b  <= w_rd_b;
                r_alu_op <= cmd_op[1:0];
                r_dst    <= cmd_dst;
            end
            if (w_cap) begin
                r_rsp_data  <= w_cap_data;
                r_rsp_carry <= w_cap_carry;
            end
        end
    end

`ifdef ALU_SEQ_ZERO_EN
    logic r_rsp_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_zero <= 1'b0;
        end else if (w_cap) begin
            r_rsp_zero <= (w_cap_data == '0);
        end
    end

    assign rsp_zero = r_rsp_zero;
`endif

    assign cmd_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_data  = r_rsp_data;
    assign rsp_carry = r_rsp_carry;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_op    = r_alu_op;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed bench for alu_seq with a behavioural ALU and a
// response scoreboard. Build with ALU_SEQ_ZERO_EN to cover rsp_zero.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [1:0] cmd_dst;
    logic [1:0] cmd_srca;
    logic [1:0] cmd_srcb;
    logic [7:0] cmd_imm;
    logic [1:0] alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_o;
    logic       alu_cout;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_carry;
`ifdef ALU_SEQ_ZERO_EN
    logic       rsp_zero;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       c;
    } exp_t;

    exp_t scb[$];

    always #5 clk = ~clk;

    alu_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_dst   (cmd_dst),
        .cmd_srca  (cmd_srca),
        .cmd_srcb  (cmd_srcb),
        .cmd_imm   (cmd_imm),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_o     (alu_o),
        .alu_cout  (alu_cout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_carry (rsp_carry)
`ifdef ALU_SEQ_ZERO_EN
        ,
        .rsp_zero  (rsp_zero)
`endif
    );

    // Behavioural 8-bit ALU; SUB carry means "no borrow".
    always_comb begin
        alu_o    = '0;
        alu_cout = 1'b0;
        case (alu_op)
            2'b00: {alu_cout, alu_o} = {1'b0, alu_a} + {1'b0, alu_b};
            2'b01: begin
                alu_o    = alu_a - alu_b;
                alu_cout = (alu_a >= alu_b);
            end
            2'b10: alu_o = alu_a & alu_b;
            default: alu_o = alu_a | alu_b;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [2:0] op, input logic [1:0] dst,
                          input logic [1:0] sa, input logic [1:0] sb,
                          input logic [7:0] imm, input string tag);
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_ready"}, cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_dst   = dst;
        cmd_srca  = sa;
        cmd_srcb  = sb;
        cmd_imm   = imm;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [1:0] dst,
                         input logic [1:0] sa, input logic [1:0] sb,
                         input logic [7:0] imm, input logic [7:0] ea,
                         input logic [7:0] eb, input logic [7:0] ed,
                         input logic ec, input string tag);
        accept(op, dst, sa, sb, imm, tag);
        scb.push_back(exp_t'{d: ed, c: ec});
        if (op[2] == 1'b0) begin
            // One EXEC cycle before the response appears.
            chk({tag, "_exec_valid"}, rsp_valid, 0);
            chk({tag, "_alu_op"}, alu_op, op[1:0]);
            chk({tag, "_alu_a"}, alu_a, ea);
            chk({tag, "_alu_b"}, alu_b, eb);
            @(posedge clk);
            #1;
        end
        chk({tag, "_valid"}, rsp_valid, 1);
        chk({tag, "_busy"}, cmd_ready, 0);
    endtask

    task automatic recv(input string tag);
        exp_t e;
        e = '0;
        chk({tag, "_sb_nonempty"}, (scb.size() > 0), 1);
        if (scb.size() > 0) begin
            e = scb.pop_front();
        end
        chk({tag, "_rvalid"}, rsp_valid, 1);
        chk({tag, "_data"}, rsp_data, e.d);
        chk({tag, "_carry"}, rsp_carry, e.c);
`ifdef ALU_SEQ_ZERO_EN
        chk({tag, "_zero"}, rsp_zero, (e.d == 8'h00));
`endif
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk({tag, "_done"}, rsp_valid, 0);
        chk({tag, "_idle"}, cmd_ready, 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_dst   = '0;
        cmd_srca  = '0;
        cmd_srcb  = '0;
        cmd_imm   = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_carry", rsp_carry, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_op", alu_op, 0);
`ifdef ALU_SEQ_ZERO_EN
        chk("rst_rsp_zero", rsp_zero, 0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(3'b100, 2'd1, 2'd0, 2'd0, 8'hF0, 8'h00, 8'h00, 8'hF0, 1'b0,
              "ldi_r1");
        recv("ldi_r1");
        issue(3'b100, 2'd2, 2'd0, 2'd0, 8'h20, 8'h00, 8'h00, 8'h20, 1'b0,
              "ldi_r2");
        recv("ldi_r2");
        issue(3'b000, 2'd3, 2'd1, 2'd2, 8'h00, 8'hF0, 8'h20, 8'h10, 1'b1,
              "add_r3");
        recv("add_r3");
        issue(3'b001, 2'd0, 2'd2, 2'd1, 8'h00, 8'h20, 8'hF0, 8'h30, 1'b0,
              "sub_r0");
        recv("sub_r0");
        issue(3'b010, 2'd1, 2'd1, 2'd1, 8'h00, 8'hF0, 8'hF0, 8'hF0, 1'b0,
              "and_r1");
        recv("and_r1");
        issue(3'b011, 2'd2, 2'd1, 2'd1, 8'h00, 8'hF0, 8'hF0, 8'hF0, 1'b0,
              "or_r1_kept");
        recv("or_r1_kept");
        issue(3'b000, 2'd0, 2'd0, 2'd0, 8'h00, 8'h30, 8'h30, 8'h60, 1'b0,
              "add_r0_self");
        recv("add_r0_self");

        // R3 = 0x10 + 0xF0 wraps to zero with carry; stall the response
        // while an unrelated LOADI R1=0x55 is offered and must be dropped.
        issue(3'b000, 2'd3, 2'd3, 2'd1, 8'h00, 8'h10, 8'hF0, 8'h00, 1'b1,
              "add_stall");
        cmd_valid = 1'b1;
        cmd_op    = 3'b100;
        cmd_dst   = 2'd1;
        cmd_imm   = 8'h55;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("stall_valid", rsp_valid, 1);
            chk("stall_data", rsp_data, 8'h00);
            chk("stall_carry", rsp_carry, 1);
            chk("stall_ready", cmd_ready, 0);
        end
        // Offer LOADI R0=0x77 in the handshake cycle: must wait one edge.
        cmd_dst = 2'd0;
        cmd_imm = 8'h77;
        recv("add_stall");
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        scb.push_back(exp_t'{d: 8'h77, c: 1'b0});
        chk("b2b_valid", rsp_valid, 1);
        recv("ldi_b2b");
        issue(3'b011, 2'd2, 2'd1, 2'd1, 8'h00, 8'hF0, 8'hF0, 8'hF0, 1'b0,
              "r1_not_55");
        recv("r1_not_55");

        issue(3'b111, 2'd1, 2'd0, 2'd0, 8'hAA, 8'h00, 8'h00, 8'h00, 1'b0,
              "rsvd");
        recv("rsvd");
        issue(3'b011, 2'd3, 2'd1, 2'd1, 8'h00, 8'hF0, 8'hF0, 8'hF0, 1'b0,
              "rsvd_r1_kept");
        recv("rsvd_r1_kept");
        issue(3'b011, 2'd3, 2'd0, 2'd0, 8'h00, 8'h77, 8'h77, 8'h77, 1'b0,
              "rsvd_r0_kept");
        recv("rsvd_r0_kept");

        // Abort an ADD R3 in EXEC with reset.
        accept(3'b000, 2'd3, 2'd1, 2'd2, 8'h00, "abort");
        chk("abort_in_exec", rsp_valid, 0);
        rst_n = 1'b0;
        #2;
        chk("abort_rst_valid", rsp_valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort_ready", cmd_ready, 1);
        chk("abort_data", rsp_data, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("abort_no_rsp", rsp_valid, 0);
        end
        issue(3'b011, 2'd0, 2'd3, 2'd3, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0,
              "r3_cleared");
        recv("r3_cleared");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
